uart_tx_mmio: RTL and testbench



---
 rtl/uart_tx_mmio.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes bytes into a small FIFO,
// STATUS reports busy/full/empty/sticky-overflow on the data-memory read path.
module uart_tx_mmio #(
    parameter int          CLKS_PER_BIT = 104,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [31:0] i_DM_addr,
    input  logic [31:0] i_DM_wd,
    input  logic [3:0]  i_DM_wen,
    input  logic        i_DM_ren,
    output logic [31:0] o_DM_rd,
    output logic        o_tx
);

    localparam int              CNT_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int              PTR_W       = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [31:0]     STATUS_ADDR = BASE_ADDR + 32'd4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic             tx_next;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic             overflow;
    logic             txdata_hit, status_hit;
    logic             push_req, push, pop, full, empty, ovf_clear;
    logic             unused_bus;

    assign txdata_hit = (i_DM_addr[31:2] == BASE_ADDR[31:2]);
    assign status_hit = (i_DM_addr[31:2] == STATUS_ADDR[31:2]);
    assign push_req   = txdata_hit && i_DM_wen[0];
    assign ovf_clear  = status_hit && i_DM_wen[0] && i_DM_wd[3];

    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
    assign push  = push_req && (!full || pop);

    assign unused_bus = ^{i_DM_addr[1:0], i_DM_wd[31:8], i_DM_wen[3:1]};

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= i_DM_wd[7:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            o_tx      <= 1'b1;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_cnt_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_next;
            o_tx      <= tx_next;
        end
    end

    // o_tx is registered from the current state, so the line trails the FSM by one cycle.
    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt;
        bit_idx_next  = bit_idx;
        shift_next    = shift_reg;
        tx_next       = 1'b1;
        pop           = 1'b0;
        unique case (state)
            IDLE: begin
                baud_cnt_next = '0;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_mem[rd_ptr[PTR_W-1:0]];
                    state_next = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (baud_cnt == CNT_LAST) begin
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                    state_next    = DATA;
                end else begin
                    baud_cnt_next = baud_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                tx_next = shift_reg[0];
                if (baud_cnt == CNT_LAST) begin
                    baud_cnt_next = '0;
                    shift_next    = {1'b0, shift_reg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (baud_cnt == CNT_LAST) begin
                    baud_cnt_next = '0;
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_mem[rd_ptr[PTR_W-1:0]];
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_cnt_next = baud_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        o_DM_rd = '0;
        if (status_hit && i_DM_ren) begin
            o_DM_rd = {28'd0, overflow, empty, full, (state != IDLE)};
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: decode vector table, exact line waveforms,
// and random byte bursts checked by a bit-sampling receiver against a byte queue.
module tb_uart_tx_mmio;

    localparam int          CPB    = 4;
    localparam int          DEPTH  = 4;
    localparam int          HALF   = CPB / 2;
    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam logic [31:0] TXDATA = BASE;
    localparam logic [31:0] STATUS = BASE + 32'd4;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic [31:0] i_DM_addr = '0;
    logic [31:0] i_DM_wd = '0;
    logic [3:0]  i_DM_wen = '0;
    logic        i_DM_ren = 1'b0;
    logic [31:0] o_DM_rd;
    logic        o_tx;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic       mon_en = 1'b0;
    logic       rx_active = 1'b0;
    int         rx_t = 0;
    int         rx_slot = 0;
    logic [7:0] rx_byte = '0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  wen;
        logic        ren;
        logic [31:0] rd;
    } vec_t;

    vec_t         vecs[11];
    logic [31:0]  st;
    logic [127:0] got_tx, want_tx, got_busy, want_busy;
    int           low_cnt;
    int           len;
    logic [7:0]   rbyte;

    uart_tx_mmio #(
        .CLKS_PER_BIT(CPB),
        .BASE_ADDR(BASE),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk(i_clk),
        .i_rstn(i_rstn),
        .i_DM_addr(i_DM_addr),
        .i_DM_wd(i_DM_wd),
        .i_DM_wen(i_DM_wen),
        .i_DM_ren(i_DM_ren),
        .o_DM_rd(o_DM_rd),
        .o_tx(o_tx)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Ideal 8N1 line level k cycles into a frame carrying byte b.
    function automatic logic line_model(input logic [7:0] b, input int k);
        int slot;
        slot = k / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        return 1'b1;
    endfunction

    // Receiver: samples mid-bit and checks each complete frame against the expected byte queue.
    always @(negedge i_clk) begin
        if (!i_rstn || !mon_en) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (o_tx == 1'b0) begin
                rx_active = 1'b1;
                rx_t      = 0;
                rx_byte   = '0;
            end
        end else begin
            rx_t++;
            if (rx_t % CPB == HALF) begin
                rx_slot = rx_t / CPB;
                if (rx_slot == 0) begin
                    check_output("rx_start_bit", o_tx, 1'b0);
                end else if (rx_slot <= 8) begin
                    rx_byte[rx_slot-1] = o_tx;
                end else begin
                    check_output("rx_stop_bit", o_tx, 1'b1);
                    if (exp_q.size() == 0) begin
                        check_output("rx_unexpected_frame", exp_q.size(), 1);
                    end else begin
                        check_output("rx_byte", rx_byte, exp_q.pop_front());
                    end
                    rx_active = 1'b0;
                end
            end
        end
    end

    task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [3:0] wen, input logic ren);
        i_DM_addr = addr;
        i_DM_wd   = wd;
        i_DM_wen  = wen;
        i_DM_ren  = ren;
        @(negedge i_clk);
    endtask

    task automatic bus_idle(input int n);
        repeat (n) apply_stimulus(32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic write_tx(input logic [7:0] b);
        apply_stimulus(TXDATA, {24'h0, b}, 4'b0001, 1'b0);
    endtask

    task automatic read_status(output logic [31:0] v);
        i_DM_addr = STATUS;
        i_DM_wd   = '0;
        i_DM_wen  = '0;
        i_DM_ren  = 1'b1;
        #1;
        v = o_DM_rd;
        @(negedge i_clk);
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || rx_active) && cyc < 3000) begin
            bus_idle(1);
            cyc++;
        end
        check_output({name, "_bytes_left"}, exp_q.size(), 0);
        bus_idle(4);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0]  = '{BASE + 32'd8,     32'h41, 4'hF,    1'b0, 32'h0};
        vecs[1]  = '{TXDATA,           32'h42, 4'b0010, 1'b0, 32'h0};
        vecs[2]  = '{BASE + 32'd8,     32'h0,  4'h0,    1'b1, 32'h0};
        vecs[3]  = '{TXDATA,           32'h0,  4'h0,    1'b1, 32'h0};
        vecs[4]  = '{STATUS,           32'h0,  4'h0,    1'b0, 32'h0};
        vecs[5]  = '{STATUS,           32'h0,  4'h0,    1'b1, 32'h4};
        vecs[6]  = '{BASE + 32'h1004,  32'h0,  4'h0,    1'b1, 32'h0};
        vecs[7]  = '{BASE + 32'd7,     32'h0,  4'h0,    1'b1, 32'h4};
        vecs[8]  = '{STATUS,           32'h8,  4'b0001, 1'b0, 32'h0};
        vecs[9]  = '{BASE - 32'd4,     32'h43, 4'b0001, 1'b1, 32'h0};
        vecs[10] = '{BASE + 32'd3,     32'h0,  4'h0,    1'b1, 32'h0};

        // Reset held with random bus traffic.
        @(negedge i_clk);
        low_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(($urandom_range(0, 1) != 0) ? TXDATA : STATUS, $urandom,
                           4'($urandom), 1'($urandom));
            if (o_tx !== 1'b1) low_cnt++;
        end
        check_output("reset_tx_low_cycles", low_cnt, 0);
        bus_idle(1);
        i_rstn = 1'b1;
        bus_idle(2);
        read_status(st);
        check_output("reset_status", st, 32'h4);
        check_output("reset_tx", o_tx, 1'b1);

        // Address decode table.
        for (int i = 0; i < 11; i++) begin
            i_DM_addr = vecs[i].addr;
            i_DM_wd   = vecs[i].wd;
            i_DM_wen  = vecs[i].wen;
            i_DM_ren  = vecs[i].ren;
            #1;
            check_output($sformatf("decode_rd_%0d", i), o_DM_rd, vecs[i].rd);
            @(negedge i_clk);
        end
        low_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            bus_idle(1);
            if (o_tx !== 1'b1) low_cnt++;
        end
        check_output("decode_no_push_tx", low_cnt, 0);
        read_status(st);
        check_output("decode_status", st, 32'h4);

        // Single byte 0x55: exact line shape and busy flag per cycle.
        mon_en = 1'b1;
        exp_q.push_back(8'h55);
        write_tx(8'h55);
        got_tx = '0; want_tx = '0; got_busy = '0; want_busy = '0;
        for (int j = 0; j < 48; j++) begin
            i_DM_addr = STATUS; i_DM_wd = '0; i_DM_wen = '0; i_DM_ren = 1'b1;
            #1;
            got_tx[j]    = o_tx;
            got_busy[j]  = o_DM_rd[0];
            want_tx[j]   = (j >= 2 && j < 42) ? line_model(8'h55, j - 2) : 1'b1;
            want_busy[j] = (j >= 1 && j <= 40);
            @(negedge i_clk);
        end
        check_output("single_frame_line", got_tx, want_tx);
        check_output("single_busy", got_busy, want_busy);
        wait_drain("single");
        read_status(st);
        check_output("single_status_after", st, 32'h4);

        // Overflow: five bytes fit because the first pop frees a slot; the sixth is dropped.
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        for (int i = 1; i <= 6; i++) write_tx(8'(i));
        read_status(st);
        // busy is also set here, since the first frame is already in flight.
        check_output("ovf_status_full_ovf", st[3:1], 3'b101);
        check_output("ovf_status_upper", st[31:4], 28'h0);
        apply_stimulus(STATUS, 32'h8, 4'b0001, 1'b0);
        read_status(st);
        check_output("ovf_cleared", st, 32'h3);
        wait_drain("overflow");
        read_status(st);
        check_output("ovf_status_after", st, 32'h4);

        // Back-to-back frames with no idle gap.
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        write_tx(8'hA5);
        write_tx(8'h3C);
        got_tx = '0; want_tx = '0;
        for (int j = 0; j < 88; j++) begin
            bus_idle(0);
            got_tx[j] = o_tx;
            if (j >= 1 && j < 41)       want_tx[j] = line_model(8'hA5, j - 1);
            else if (j >= 41 && j < 81) want_tx[j] = line_model(8'h3C, j - 41);
            else                        want_tx[j] = 1'b1;
            bus_idle(1);
        end
        check_output("b2b_line", got_tx, want_tx);
        wait_drain("b2b");

        // Random bursts that never exceed the FIFO capacity.
        for (int b = 0; b < 6; b++) begin
            len = $urandom_range(1, DEPTH);
            for (int k = 0; k < len; k++) begin
                rbyte = 8'($urandom);
                exp_q.push_back(rbyte);
                write_tx(rbyte);
                bus_idle($urandom_range(0, 3));
            end
            wait_drain($sformatf("random_%0d", b));
            read_status(st);
            check_output($sformatf("random_status_%0d", b), st, 32'h4);
        end

        // Reset during DATA bit 3 with a second byte still queued.
        mon_en = 1'b0;
        write_tx(8'h96);
        write_tx(8'h11);
        bus_idle(18);
        check_output("midreset_pre_bit3", o_tx, 1'b0);
        i_rstn = 1'b0;
        #1;
        check_output("midreset_tx_async", o_tx, 1'b1);
        i_DM_addr = STATUS; i_DM_ren = 1'b1;
        #1;
        check_output("midreset_status", o_DM_rd, 32'h4);
        @(negedge i_clk);
        bus_idle(2);
        i_rstn = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            bus_idle(1);
            if (o_tx !== 1'b1) low_cnt++;
        end
        check_output("midreset_no_residual", low_cnt, 0);
        read_status(st);
        check_output("midreset_status_after", st, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
